// File: rtl/intraloop_scheduler.sv
// rtl/intraloop_scheduler.sv - raster-order macroblock issue controller for the intra-prediction loop.
// Issue is gated by intra neighbour dependencies and an in-flight credit limit; retirement is strictly in order.
module intraloop_scheduler #(
  parameter int MB_COLS      = 4,
  parameter int MB_ROWS      = 2,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic                                  retire_valid,
  input  logic [31:0]                           retire_mbnumber,
  output logic                                  pipe_enable,
  output logic                                  issue_valid,
  output logic [31:0]                           mbnumber,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]     inflight,
  output logic                                  busy,
  output logic                                  frame_done,
  output logic                                  err
);

  localparam int              IW      = $clog2(MAX_INFLIGHT + 1);
  localparam logic [31:0]     TOTAL   = 32'(MB_COLS * MB_ROWS);
  localparam logic [31:0]     COLS    = 32'(MB_COLS);
  localparam logic [IW-1:0]   CREDITS = IW'(MAX_INFLIGHT);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t      state, state_next;
  logic [31:0] next_mb, retired, col, row;
  logic        dep_ok, issue, retire_ok, retire_bad;

  // retired > dep, with dep = left neighbour or top-right (top when the frame is one column wide)
  always_comb begin
    dep_ok = 1'b1;
    if (col != 32'd0)
      dep_ok = (retired >= next_mb);
    else if (row != 32'd0) begin
      if (MB_COLS == 1)
        dep_ok = (retired >= next_mb);
      else
        dep_ok = (retired > next_mb - COLS + 32'd1);
    end
  end

  always_comb begin
    issue      = (state == RUN) && (next_mb < TOTAL) && (inflight < CREDITS) && dep_ok;
    retire_ok  = retire_valid && ((state == RUN) || (state == DRAIN)) &&
                 (inflight != '0) && (retire_mbnumber == retired);
    retire_bad = retire_valid && !retire_ok;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (issue && (next_mb == TOTAL - 32'd1)) state_next = DRAIN;
      DRAIN:   if (inflight == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pipe_enable = (state == RUN) || (state == DRAIN);
    busy        = (state == RUN) || (state == DRAIN);
    frame_done  = (state == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issue_valid <= 1'b0;
      mbnumber    <= 32'd0;
      next_mb     <= 32'd0;
      retired     <= 32'd0;
      col         <= 32'd0;
      row         <= 32'd0;
      inflight    <= '0;
      err         <= 1'b0;
    end else begin
      issue_valid <= issue;
      if (issue) begin
        mbnumber <= next_mb;
        next_mb  <= next_mb + 32'd1;
        if (col == COLS - 32'd1) begin
          col <= 32'd0;
          row <= row + 32'd1;
        end else begin
          col <= col + 32'd1;
        end
      end
      if (retire_ok)
        retired <= retired + 32'd1;
      case ({issue, retire_ok})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
      if (retire_bad)
        err <= 1'b1;
      // a new frame starts from a clean slate, including the sticky error
      if ((state == IDLE) && start) begin
        next_mb  <= 32'd0;
        retired  <= 32'd0;
        col      <= 32'd0;
        row      <= 32'd0;
        inflight <= '0;
        err      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_intraloop_scheduler.sv
// tb/tb_intraloop_scheduler.sv - randomized bench for intraloop_scheduler against a count-based frame model.
// Three instances: 4x2 with 4 credits, 1x1 with 1 credit, 4x2 with 1 credit.
module tb_intraloop_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_s [3];
  logic        rv_s    [3];
  logic [31:0] rn_s    [3];

  logic        pe_o   [3];
  logic        iv_o   [3];
  logic [31:0] mb_o   [3];
  logic        busy_o [3];
  logic        fd_o   [3];
  logic        err_o  [3];
  logic [2:0]  inf0;
  logic [0:0]  inf1;
  logic [0:0]  inf2;

  int P_COLS [3] = '{4, 1, 4};
  int P_ROWS [3] = '{2, 1, 2};
  int P_MAXI [3] = '{4, 1, 1};

  // model: 0 idle, 1 run, 2 drain, 3 done; issued/retired are plain frame counts
  int m_mode [3];
  int m_iss  [3];
  int m_ret  [3];
  int m_mb   [3];
  bit m_err  [3];
  bit m_iv   [3];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  intraloop_scheduler #(.MB_COLS(4), .MB_ROWS(2), .MAX_INFLIGHT(4)) u0 (
    .clk(clk), .reset(reset), .start(start_s[0]), .retire_valid(rv_s[0]),
    .retire_mbnumber(rn_s[0]), .pipe_enable(pe_o[0]), .issue_valid(iv_o[0]),
    .mbnumber(mb_o[0]), .inflight(inf0), .busy(busy_o[0]), .frame_done(fd_o[0]), .err(err_o[0]));

  intraloop_scheduler #(.MB_COLS(1), .MB_ROWS(1), .MAX_INFLIGHT(1)) u1 (
    .clk(clk), .reset(reset), .start(start_s[1]), .retire_valid(rv_s[1]),
    .retire_mbnumber(rn_s[1]), .pipe_enable(pe_o[1]), .issue_valid(iv_o[1]),
    .mbnumber(mb_o[1]), .inflight(inf1), .busy(busy_o[1]), .frame_done(fd_o[1]), .err(err_o[1]));

  intraloop_scheduler #(.MB_COLS(4), .MB_ROWS(2), .MAX_INFLIGHT(1)) u2 (
    .clk(clk), .reset(reset), .start(start_s[2]), .retire_valid(rv_s[2]),
    .retire_mbnumber(rn_s[2]), .pipe_enable(pe_o[2]), .issue_valid(iv_o[2]),
    .mbnumber(mb_o[2]), .inflight(inf2), .busy(busy_o[2]), .frame_done(fd_o[2]), .err(err_o[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  function automatic int inf_of(int i);
    case (i)
      0:       return int'(inf0);
      1:       return int'(inf1);
      default: return int'(inf2);
    endcase
  endfunction

  function automatic bit dep_ok(int cols, int n, int ret);
    int c = n % cols;
    int r = n / cols;
    if (c > 0) return ret > n - 1;
    if (r > 0) return ret > ((cols == 1) ? n - 1 : n - cols + 1);
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_mode[i] = 0; m_iss[i] = 0; m_ret[i] = 0;
      m_mb[i] = 0; m_err[i] = 0; m_iv[i] = 0;
    end
  endtask

  task automatic model_step(int i);
    int  total = P_COLS[i] * P_ROWS[i];
    int  infl  = m_iss[i] - m_ret[i];
    bit  fire, rok;
    int  nmode = m_mode[i];
    fire = (m_mode[i] == 1) && (m_iss[i] < total) && (infl < P_MAXI[i]) &&
           dep_ok(P_COLS[i], m_iss[i], m_ret[i]);
    rok  = rv_s[i] && (m_mode[i] == 1 || m_mode[i] == 2) && (infl > 0) && (rn_s[i] == 32'(m_ret[i]));
    case (m_mode[i])
      0: if (start_s[i]) nmode = 1;
      1: if (fire && m_iss[i] == total - 1) nmode = 2;
      2: if (infl == 0) nmode = 3;
      default: nmode = 0;
    endcase
    m_iv[i] = fire;
    if (fire) begin
      m_mb[i] = m_iss[i];
      m_iss[i]++;
    end
    if (rok) m_ret[i]++;
    if (rv_s[i] && !rok) m_err[i] = 1'b1;
    if (m_mode[i] == 0 && start_s[i]) begin
      m_iss[i] = 0; m_ret[i] = 0; m_err[i] = 0;
    end
    m_mode[i] = nmode;
  endtask

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      bit act = (m_mode[i] == 1 || m_mode[i] == 2);
      check($sformatf("u%0d.pipe_enable", i), 32'(pe_o[i]), 32'(act));
      check($sformatf("u%0d.busy", i), 32'(busy_o[i]), 32'(act));
      check($sformatf("u%0d.frame_done", i), 32'(fd_o[i]), 32'(m_mode[i] == 3));
      check($sformatf("u%0d.issue_valid", i), 32'(iv_o[i]), 32'(m_iv[i]));
      check($sformatf("u%0d.mbnumber", i), mb_o[i], 32'(m_mb[i]));
      check($sformatf("u%0d.inflight", i), 32'(inf_of(i)), 32'(m_iss[i] - m_ret[i]));
      check($sformatf("u%0d.err", i), 32'(err_o[i]), 32'(m_err[i]));
    end
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 3; i++) begin
      start_s[i] = 1'b0; rv_s[i] = 1'b0; rn_s[i] = 32'd0;
    end
  endtask

  // called just after a falling edge with inputs already set; returns just after the next falling edge
  task automatic cycle();
    for (int i = 0; i < 3; i++) model_step(i);
    @(posedge clk);
    #1 compare_all();
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic do_reset(int n);
    reset = 1'b0;
    clear_inputs();
    model_reset();
    #1 compare_all();
    repeat (n) begin
      @(posedge clk);
      #1 compare_all();
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic gen_random(int i);
    if (m_mode[i] == 0) begin
      start_s[i] = ($urandom_range(0, 3) == 0);
      if (!start_s[i] && $urandom_range(0, 29) == 0) begin
        rv_s[i] = 1'b1; rn_s[i] = $urandom;
      end
    end else begin
      start_s[i] = ($urandom_range(0, 19) == 0);
      if ((m_iss[i] - m_ret[i]) > 0 && $urandom_range(0, 2) != 0) begin
        rv_s[i] = 1'b1;
        rn_s[i] = ($urandom_range(0, 24) == 0) ? 32'(m_ret[i] + 1 + $urandom_range(0, 3)) : 32'(m_ret[i]);
      end else if ($urandom_range(0, 39) == 0) begin
        rv_s[i] = 1'b1; rn_s[i] = 32'(m_ret[i]);
      end
    end
  endtask

  initial begin
    clear_inputs();
    model_reset();
    @(negedge clk);
    do_reset(5);

    // retire while idle: sticky error, nothing else moves
    for (int i = 0; i < 3; i++) begin rv_s[i] = 1'b1; rn_s[i] = 32'd0; end
    cycle();
    check("idle_retire_err", 32'(err_o[0]), 32'd1);
    check("idle_retire_inflight", 32'(inf0), 32'd0);

    // edge 0: start all; edges 1..11 quiet; edge 12 retire mb 0 everywhere
    for (int i = 0; i < 3; i++) start_s[i] = 1'b1;
    cycle();
    for (int e = 1; e <= 14; e++) begin
      if (e == 12)
        for (int i = 0; i < 3; i++) begin rv_s[i] = 1'b1; rn_s[i] = 32'd0; end
      cycle();
      if (e == 1) begin
        check("1x1_first_issue", 32'(iv_o[1]), 32'd1);
        check("1x1_first_mb", mb_o[1], 32'd0);
      end
      if (e == 12) check("left_dep_wait", 32'(iv_o[0]), 32'd0);
      if (e == 13) begin
        check("1x1_frame_done", 32'(fd_o[1]), 32'd1);
        check("left_dep_issue", 32'(iv_o[0]), 32'd1);
        check("left_dep_mb", mb_o[0], 32'd1);
      end
      if (e == 14) check("1x1_idle_busy", 32'(busy_o[1]), 32'd0);
    end

    // out-of-order retire on u0 with mb 1 in flight
    rv_s[0] = 1'b1; rn_s[0] = 32'd5;
    cycle();
    check("ooo_err", 32'(err_o[0]), 32'd1);
    check("ooo_inflight", 32'(inf0), 32'd1);

    // retire through mb 2 then hold: mb 3 and mb 4 issue back to back on u0, u2 waits on credit
    for (int k = 0; k < 30; k++) begin
      for (int i = 0; i < 3; i += 2)
        if ((m_iss[i] - m_ret[i]) > 0 && m_ret[i] < 3) begin
          rv_s[i] = 1'b1; rn_s[i] = 32'(m_ret[i]);
        end
      cycle();
    end
    check("row_boundary_inflight", 32'(inf0), 32'd2);
    check("row_boundary_mb", mb_o[0], 32'd4);
    check("credit1_inflight", 32'(inf2), 32'd1);
    check("credit1_mb", mb_o[2], 32'd3);

    // mid-frame reset, then a clean restart
    do_reset(2);
    check("midreset_inflight", 32'(inf0), 32'd0);
    for (int i = 0; i < 3; i++) start_s[i] = 1'b1;
    cycle();
    cycle();
    check("restart_mb0", mb_o[0], 32'd0);
    check("restart_issue", 32'(iv_o[0]), 32'd1);

    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 399) == 0)
        do_reset($urandom_range(1, 3));
      else begin
        for (int i = 0; i < 3; i++) gen_random(i);
        cycle();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
